layer_line_buffer_pp: RTL and testbench
=======================================

LAYER_LINE_BUFFER_PP -- requirements
Module: layer_line_buffer_pp

Interface
REQ-001 Parameter DATA_W, default 8, pixel/colour-index width in bits.
REQ-002 Parameter LINE_LEN, default 640, entries per line buffer.
REQ-003 Parameter IDX_W, default 10, index width; SHALL satisfy 2^IDX_W >= LINE_LEN.
REQ-004 Parameter CLEAR_VAL, default 0, DATA_W-bit value returned for unwritten or out-of-range entries.
REQ-005 clk  input  1  single clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 wr_idx  input  IDX_W  renderer write index.
REQ-008 wr_data  input  DATA_W  renderer write data.
REQ-009 wr_en  input  1  renderer write strobe.
REQ-010 render_done  input  1  single-cycle pulse; renderer has finished the current line.
REQ-011 line_swap  input  1  single-cycle pulse from composer at start of each display line.
REQ-012 rd_idx  input  IDX_W  composer read index.
REQ-013 rd_data  output  DATA_W  composer read data.
REQ-014 active_render_buffer  output  1  buffer (0/1) currently owned by the renderer.
REQ-015 render_busy  output  1  high while renderer may write (state RENDER).
REQ-016 underrun  output  1  single-cycle pulse on swap before render_done.
REQ-017 underrun_cnt  output  8  saturating underrun count.

Function
REQ-018 Storage SHALL be two banks of LINE_LEN x DATA_W; renderer owns bank active_render_buffer, composer owns the other.
REQ-019 States: IDLE (after reset), RENDER, READY; render_busy = (state == RENDER).
REQ-020 IDLE: writes dropped; line_swap -> toggle active_render_buffer, go RENDER, no underrun.
REQ-021 RENDER: wr_en with wr_idx < LINE_LEN writes wr_data to render bank; render_done -> READY.
REQ-022 READY: writes dropped, render_done ignored; line_swap -> toggle buffer, go RENDER.
REQ-023 line_swap in RENDER without simultaneous render_done -> toggle buffer, stay RENDER, underrun pulse next cycle, underrun_cnt +1 saturating at 255.
REQ-024 line_swap and render_done in the same cycle in RENDER -> normal swap, no underrun.
REQ-025 Swap takes effect at the next edge; a write in the swap cycle goes to the pre-swap render bank.
REQ-026 Read latency exactly 1 cycle: rd_idx and bank select sampled at edge t, rd_data valid after edge t+1; a read in the swap cycle uses the pre-swap composer bank.
REQ-027 rd_idx >= LINE_LEN SHALL return CLEAR_VAL; wr_idx >= LINE_LEN writes SHALL be ignored.
REQ-028 Renderer and composer SHALL never access the same bank in one cycle; no read-during-write hazard exists.

Reset
REQ-029 On rst_n low: state IDLE, active_render_buffer 0, render_busy 0, underrun 0, underrun_cnt 0, rd_data CLEAR_VAL.
REQ-030 Reset mid-line SHALL abandon the line; memory contents need not be cleared.
REQ-031 Deassertion is synchronised externally; block resumes in IDLE.

Configuration
REQ-032 Macro LAYER_LINE_BUFFER_PP_VALID_MASK_EN SHALL select per-entry written-bit tracking.
REQ-033 Defined: each bank has a LINE_LEN-bit valid map; writes set the bit; on swap the new render bank's map clears in one cycle; reads of unset entries return CLEAR_VAL.
REQ-034 Undefined: no valid maps; reads return raw memory contents (stale data from previous lines permitted).

Verification
REQ-035 Reset, line_swap, write idx 0..639 = idx[7:0], render_done, line_swap, read 0..639 -> rd_data = idx[7:0] one cycle after each rd_idx.
REQ-036 Two line_swap pulses without render_done between -> underrun pulse once, underrun_cnt = 1; 300 such swaps -> underrun_cnt = 255.
REQ-037 render_done and line_swap same cycle -> underrun stays 0, active_render_buffer toggles.
REQ-038 Write in READY state at idx 5 = 0xAA, then swap, read idx 5 -> not 0xAA (previous content / CLEAR_VAL).
REQ-039 With VALID_MASK_EN: write only idx 10 = 0x33, swap, read idx 9/10/11 -> 0x00/0x33/0x00; without macro idx 9 returns stale data.
REQ-040 Assert rst_n low mid-RENDER -> all outputs reset values within same cycle; rd_idx 700 after swap -> CLEAR_VAL.

Source files
------------

// File: rtl/layer_line_buffer_pp.sv
// layer_line_buffer_pp: ping-pong line buffer between a line renderer and a
// display composer. The renderer fills one bank while the composer reads the
// other; line_swap exchanges the roles.
// Optional build macro: LAYER_LINE_BUFFER_PP_VALID_MASK_EN adds a per-entry
// written-bit map to each bank so unwritten entries read back as CLEAR_VAL.
module layer_line_buffer_pp #(
    parameter int unsigned        DATA_W    = 8,
    parameter int unsigned        LINE_LEN  = 640,
    parameter int unsigned        IDX_W     = 10,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic              render_done,
    input  logic              line_swap,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic              active_render_buffer,
    output logic              render_busy,
    output logic              underrun,
    output logic [7:0]        underrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RENDER = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    // One extra bit so LINE_LEN == 2**IDX_W is representable.
    localparam logic [IDX_W:0] LP_LEN = (IDX_W+1)'(LINE_LEN);

    state_t            r_state;
    logic              r_active;
    logic              r_busy;
    logic              r_underrun;
    logic [7:0]        r_ucnt;
    logic [DATA_W-1:0] r_rd_data;

    logic [DATA_W-1:0] r_bank0 [0:LINE_LEN-1];
    logic [DATA_W-1:0] r_bank1 [0:LINE_LEN-1];

    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr_en;
    logic [DATA_W-1:0] w_rd_raw;
    logic              w_rd_vld;

    assign w_wr_in_range = ({1'b0, wr_idx} < LP_LEN);
    assign w_rd_in_range = ({1'b0, rd_idx} < LP_LEN);

    // Writes only land while rendering; r_active is the pre-swap render bank
    // even in a swap cycle, so a same-cycle write goes to the old bank.
    assign w_wr_en = wr_en && (r_state == ST_RENDER) && w_wr_in_range;

    // The composer always owns the bank the renderer does not.
    assign w_rd_raw = r_active ? r_bank0[rd_idx] : r_bank1[rd_idx];

    // Ownership FSM: swap handling, busy flag and underrun accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_active   <= 1'b0;
            r_busy     <= 1'b0;
            r_underrun <= 1'b0;
            r_ucnt     <= '0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (line_swap) begin
                        r_active <= ~r_active;
                        r_state  <= ST_RENDER;
                        r_busy   <= 1'b1;
                    end
                end
                ST_RENDER: begin
                    if (line_swap) begin
                        r_active <= ~r_active;
                        r_busy   <= 1'b1;
                        // A swap without a finished line abandons it and
                        // restarts rendering into the freshly handed-over bank.
                        if (!render_done) begin
                            r_underrun <= 1'b1;
                            if (r_ucnt != 8'hFF) begin
                                r_ucnt <= r_ucnt + 8'd1;
                            end
                        end
                    end else if (render_done) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (line_swap) begin
                        r_active <= ~r_active;
                        r_state  <= ST_RENDER;
                        r_busy   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Bank storage; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (w_wr_en && !r_active) begin
            r_bank0[wr_idx] <= wr_data;
        end
        if (w_wr_en && r_active) begin
            r_bank1[wr_idx] <= wr_data;
        end
    end

`ifdef LAYER_LINE_BUFFER_PP_VALID_MASK_EN
    logic [LINE_LEN-1:0] r_vld0;
    logic [LINE_LEN-1:0] r_vld1;

    // Written-bit maps: set on write, cleared when the bank becomes the
    // render bank. The cleared bank is never the one being written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld0 <= '0;
            r_vld1 <= '0;
        end else begin
            if (w_wr_en && !r_active) begin
                r_vld0[wr_idx] <= 1'b1;
            end
            if (w_wr_en && r_active) begin
                r_vld1[wr_idx] <= 1'b1;
            end
            if (line_swap && r_active) begin
                r_vld0 <= '0;
            end
            if (line_swap && !r_active) begin
                r_vld1 <= '0;
            end
        end
    end

    assign w_rd_vld = r_active ? r_vld0[rd_idx] : r_vld1[rd_idx];
`else
    assign w_rd_vld = 1'b1;
`endif

    // Registered composer read, one cycle latency, out-of-range -> CLEAR_VAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data <= CLEAR_VAL;
        end else if (w_rd_in_range && w_rd_vld) begin
            r_rd_data <= w_rd_raw;
        end else begin
            r_rd_data <= CLEAR_VAL;
        end
    end

    assign rd_data              = r_rd_data;
    assign active_render_buffer = r_active;
    assign render_busy          = r_busy;
    assign underrun             = r_underrun;
    assign underrun_cnt         = r_ucnt;

endmodule

// File: tb/tb_layer_line_buffer_pp.sv
// Scoreboard bench for layer_line_buffer_pp (default parameters).
// Reads push their expected data into a queue; a negedge monitor pops and
// compares one cycle after each read was issued.
module tb_layer_line_buffer_pp;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] wr_idx = '0;
    logic [7:0] wr_data = '0;
    logic       wr_en = 1'b0;
    logic       render_done = 1'b0;
    logic       line_swap = 1'b0;
    logic [9:0] rd_idx = '0;
    logic [7:0] rd_data;
    logic       active_render_buffer;
    logic       render_busy;
    logic       underrun;
    logic [7:0] underrun_cnt;

    logic       rd_req = 1'b0;
    logic       rd_req_q = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;
    int         ur_seen = 0;

    typedef struct {
        int         idx;
        logic [7:0] exp;
    } rd_exp_t;

    rd_exp_t sb[$];

    layer_line_buffer_pp #(
        .DATA_W    (8),
        .LINE_LEN  (640),
        .IDX_W     (10),
        .CLEAR_VAL (8'h00)
    ) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .wr_idx               (wr_idx),
        .wr_data              (wr_data),
        .wr_en                (wr_en),
        .render_done          (render_done),
        .line_swap            (line_swap),
        .rd_idx               (rd_idx),
        .rd_data              (rd_data),
        .active_render_buffer (active_render_buffer),
        .render_busy          (render_busy),
        .underrun             (underrun),
        .underrun_cnt         (underrun_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_req_q <= rd_req;

    // Monitor: count underrun pulses, pop and compare read results.
    always @(negedge clk) begin
        rd_exp_t e;
        if (underrun === 1'b1) ur_seen++;
        if (rd_req_q) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: got %02h with no expected entry", rd_data);
            end else begin
                e = sb.pop_front();
                if (rd_data !== e.exp) begin
                    n_err++;
                    $display("FAIL rd_data[%0d]: got %02h expected %02h", e.idx, rd_data, e.exp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic rd(input int idx, input logic [7:0] exp);
        rd_exp_t e;
        rd_idx = 10'(idx);
        rd_req = 1'b1;
        e.idx = idx;
        e.exp = exp;
        sb.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        // Reset state
        cyc(); cyc();
        chk("rst_active", 32'(active_render_buffer), 32'd0);
        chk("rst_busy", 32'(render_busy), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_cnt", 32'(underrun_cnt), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'h00);
        rst_n = 1'b1;
        cyc();

        // IDLE -> RENDER, render bank 1
        line_swap = 1'b1; cyc(); line_swap = 1'b0;
        chk("swap1_active", 32'(active_render_buffer), 32'd1);
        chk("swap1_busy", 32'(render_busy), 32'd1);
        for (int i = 0; i < 640; i++) begin
            b = 8'(i);
            wr_en = 1'b1; wr_idx = 10'(i); wr_data = b;
            cyc();
        end
        wr_idx = 10'd700; wr_data = 8'hEE; cyc();
        wr_en = 1'b0;
        render_done = 1'b1; cyc(); render_done = 1'b0;
        chk("ready_busy", 32'(render_busy), 32'd0);
        // Dropped write in READY
        wr_en = 1'b1; wr_idx = 10'd5; wr_data = 8'hAA; cyc(); wr_en = 1'b0;
        line_swap = 1'b1; cyc(); line_swap = 1'b0;
        chk("swap2_active", 32'(active_render_buffer), 32'd0);
        chk("swap2_busy", 32'(render_busy), 32'd1);

        // Read bank 1 while rendering bank 0 with inverted pattern
        for (int i = 0; i < 640; i++) begin
            b = 8'(i);
            wr_en = 1'b1; wr_idx = 10'(i); wr_data = ~b;
            rd(i, b);
            cyc();
        end
        wr_en = 1'b0;
        rd(640, 8'h00); cyc();
        rd(700, 8'h00); cyc();
        rd_req = 1'b0;
        cyc(); cyc();

        // Swap with render_done in the same cycle; write and read in swap cycle
        wr_en = 1'b1; wr_idx = 10'd12; wr_data = 8'h5C;
        line_swap = 1'b1; render_done = 1'b1;
        rd(7, 8'h07);
        cyc();
        wr_en = 1'b0; line_swap = 1'b0; render_done = 1'b0;
        rd(12, 8'h5C); cyc();
        rd(13, 8'hF2); cyc();
        rd_req = 1'b0;
        chk("sameswap_active", 32'(active_render_buffer), 32'd1);
        chk("sameswap_busy", 32'(render_busy), 32'd1);
        cyc();
        chk("sameswap_nounderrun", 32'(ur_seen), 32'd0);

        // Fresh render of bank 0 with a single write at idx 10
        render_done = 1'b1; cyc(); render_done = 1'b0;
        line_swap = 1'b1; cyc(); line_swap = 1'b0;
        chk("swap3_active", 32'(active_render_buffer), 32'd0);
        wr_en = 1'b1; wr_idx = 10'd10; wr_data = 8'h33; cyc(); wr_en = 1'b0;
        render_done = 1'b1; line_swap = 1'b1; cyc();
        render_done = 1'b0; line_swap = 1'b0;
`ifdef LAYER_LINE_BUFFER_PP_VALID_MASK_EN
        rd(9, 8'h00); cyc();
        rd(10, 8'h33); cyc();
        rd(11, 8'h00); cyc();
`else
        rd(9, 8'hF6); cyc();
        rd(10, 8'h33); cyc();
        rd(11, 8'hF4); cyc();
`endif
        rd_req = 1'b0;
        cyc();
        chk("pre_underrun_cnt", 32'(underrun_cnt), 32'd0);

        // Underrun: lone swap while rendering
        line_swap = 1'b1; cyc(); line_swap = 1'b0;
        chk("underrun_pulse", 32'(underrun), 32'd1);
        chk("underrun_cnt1", 32'(underrun_cnt), 32'd1);
        cyc();
        chk("underrun_drop", 32'(underrun), 32'd0);
        chk("underrun_once", 32'(ur_seen), 32'd1);
        for (int i = 0; i < 299; i++) begin
            line_swap = 1'b1; cyc(); line_swap = 1'b0; cyc();
        end
        chk("underrun_sat", 32'(underrun_cnt), 32'd255);
        chk("underrun_pulses", 32'(ur_seen), 32'd300);
        chk("underrun_active", 32'(active_render_buffer), 32'd1);
        chk("underrun_busy", 32'(render_busy), 32'd1);

        // Asynchronous reset in the middle of RENDER
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_active", 32'(active_render_buffer), 32'd0);
        chk("arst_busy", 32'(render_busy), 32'd0);
        chk("arst_underrun", 32'(underrun), 32'd0);
        chk("arst_cnt", 32'(underrun_cnt), 32'd0);
        chk("arst_rd_data", 32'(rd_data), 32'h00);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        line_swap = 1'b1; cyc(); line_swap = 1'b0;
        chk("post_rst_active", 32'(active_render_buffer), 32'd1);
        rd(700, 8'h00); cyc();
`ifdef LAYER_LINE_BUFFER_PP_VALID_MASK_EN
        rd(3, 8'h00); cyc();
`else
        rd(3, 8'hFC); cyc();
`endif
        rd_req = 1'b0;
        cyc(); cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
